// File: rtl/jtoutrun_ram_arb.sv
// Shared work RAM arbiter for the OutRun main and sub 68000 buses.
// Two level-held requesters share one SDRAM slot. Arbitration is round-robin,
// with a forced one-cycle gap between accesses so the memory controller
// always sees a fresh rising edge on mem_cs. Every output is registered.
module jtoutrun_ram_arb #(
   parameter int AW = 14
) (
   input  logic          rst,
   input  logic          clk,
   // main CPU bus
   input  logic          main_cs,
   input  logic [AW:1]   main_addr,
   input  logic [15:0]   main_dout,
   input  logic [1:0]    main_dsn,
   input  logic          main_rnw,
   output logic [15:0]   main_din,
   output logic          main_ok,
   // sub CPU bus
   input  logic          sub_cs,
   input  logic [AW:1]   sub_addr,
   input  logic [15:0]   sub_dout,
   input  logic [1:0]    sub_dsn,
   input  logic          sub_rnw,
   output logic [15:0]   sub_din,
   output logic          sub_ok,
   // SDRAM slot
   output logic          mem_cs,
   output logic [AW:1]   mem_addr,
   output logic [15:0]   mem_din,
   output logic [1:0]    mem_we,
   output logic          mem_rnw,
   input  logic [15:0]   mem_dout,
   input  logic          mem_ok
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      GAP    = 2'd2
   } state_t;

   state_t        state, state_nx;
   logic          gnt,   gnt_nx;      // 0 = main, 1 = sub
   logic          last,  last_nx;     // port granted most recently
   logic          mem_cs_nx;
   logic [AW:1]   mem_addr_nx;
   logic [15:0]   mem_din_nx;
   logic [1:0]    mem_we_nx;
   logic          mem_rnw_nx;
   logic [15:0]   main_din_nx, sub_din_nx;
   logic          main_ok_nx,  sub_ok_nx;

   logic          pend_main, pend_sub, sel;
   logic          gnt_cs;

   // A requester only counts as pending until it has been acknowledged.
   // It has to drop cs for one cycle before it can ask again.
   assign pend_main = main_cs & ~main_ok;
   assign pend_sub  = sub_cs  & ~sub_ok;
   // Under contention the port that did not win last time is picked.
   assign sel       = (pend_main & pend_sub) ? ~last : pend_sub;
   assign gnt_cs    = gnt ? sub_cs : main_cs;

   // Next-state and next-output logic for the arbiter FSM
   always_comb begin
      // NOTE: every signal gets a default hold value first. Otherwise a path
      // through the case below that does not assign a signal would infer a latch.
      state_nx    = state;
      gnt_nx      = gnt;
      last_nx     = last;
      mem_cs_nx   = mem_cs;
      mem_addr_nx = mem_addr;
      mem_din_nx  = mem_din;
      mem_we_nx   = mem_we;
      mem_rnw_nx  = mem_rnw;
      main_din_nx = main_din;
      sub_din_nx  = sub_din;
      // ok drops on the first edge where the owner's cs is seen low
      main_ok_nx  = main_ok & main_cs;
      sub_ok_nx   = sub_ok  & sub_cs;

      case (state)
         IDLE: begin
            if (pend_main | pend_sub) begin
               gnt_nx      = sel;
               last_nx     = sel;
               mem_cs_nx   = 1'b1;
               mem_addr_nx = sel ? sub_addr : main_addr;
               mem_din_nx  = sel ? sub_dout : main_dout;
               mem_rnw_nx  = sel ? sub_rnw  : main_rnw;
               mem_we_nx   = sel ? (~sub_dsn  & {2{~sub_rnw}})
                                 : (~main_dsn & {2{~main_rnw}});
               state_nx    = ACCESS;
            end
         end
         ACCESS: begin
            // The SDRAM access always runs to completion. If the requester
            // has already given up, the result is simply dropped.
            if (mem_ok) begin
               mem_cs_nx = 1'b0;
               state_nx  = GAP;
               if (gnt_cs) begin
                  if (gnt) begin
                     sub_ok_nx = 1'b1;
                     if (mem_rnw) sub_din_nx = mem_dout;
                  end else begin
                     main_ok_nx = 1'b1;
                     if (mem_rnw) main_din_nx = mem_dout;
                  end
               end
            end
         end
         GAP: begin
            // mem_cs stays low for a cycle. A lingering mem_ok is ignored.
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 1'b0;
         last     <= 1'b1;
         mem_cs   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         mem_we   <= '0;
         mem_rnw  <= 1'b1;
         main_din <= '0;
         sub_din  <= '0;
         main_ok  <= 1'b0;
         sub_ok   <= 1'b0;
      end else begin
         // NOTE: use non-blocking assignments here. All registers must update
         // together from the values the combinational block computed.
         state    <= state_nx;
         gnt      <= gnt_nx;
         last     <= last_nx;
         mem_cs   <= mem_cs_nx;
         mem_addr <= mem_addr_nx;
         mem_din  <= mem_din_nx;
         mem_we   <= mem_we_nx;
         mem_rnw  <= mem_rnw_nx;
         main_din <= main_din_nx;
         sub_din  <= sub_din_nx;
         main_ok  <= main_ok_nx;
         sub_ok   <= sub_ok_nx;
      end
   end

endmodule
